// File: rtl/mips_mcctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes, mux selects and the alu_t aluop consumed by aludec.
module mips_mcctrl #(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               branch,
    output logic               branchne,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               extop,
    output logic [1:0]         pcsrc,
    output logic [3:0]         aluop,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StRtypeEx  = 4'd6,
        StRtypeWb  = 4'd7,
        StBranchEx = 4'd8,
        StImmEx    = 4'd9,
        StImmWb    = 4'd10,
        StJEx      = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'd0;
    localparam logic [5:0] OpJ     = 6'd2;
    localparam logic [5:0] OpBeq   = 6'd4;
    localparam logic [5:0] OpBne   = 6'd5;
    localparam logic [5:0] OpAddi  = 6'd8;
    localparam logic [5:0] OpSlti  = 6'd10;
    localparam logic [5:0] OpAndi  = 6'd12;
    localparam logic [5:0] OpOri   = 6'd13;
    localparam logic [5:0] OpXori  = 6'd14;
    localparam logic [5:0] OpLui   = 6'd15;
    localparam logic [5:0] OpLw    = 6'd35;
    localparam logic [5:0] OpSw    = 6'd43;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSlt   = 4'd2;
    localparam logic [3:0] AluAnd   = 4'd4;
    localparam logic [3:0] AluOr    = 4'd5;
    localparam logic [3:0] AluXor   = 4'd6;
    localparam logic [3:0] AluLui   = 4'd7;
    localparam logic [3:0] AluFunct = 4'd15;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_rdy;

    logic   pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;
    logic [3:0] imm_aluop;
    logic       imm_extop;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        case (state_q)
            StFetch:    state_d = mem_rdy ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OpRtype:                                      state_d = StRtypeEx;
                    OpLw, OpSw:                                   state_d = StMemAdr;
                    OpBeq, OpBne:                                 state_d = StBranchEx;
                    OpAddi, OpSlti, OpAndi, OpOri, OpXori, OpLui: state_d = StImmEx;
                    OpJ:                                          state_d = StJEx;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr:   state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:    state_d = mem_rdy ? StMemWb : StMemRd;
            StMemWb:    state_d = StFetch;
            StMemWr:    state_d = mem_rdy ? StFetch : StMemWr;
            StRtypeEx:  state_d = StRtypeWb;
            StRtypeWb:  state_d = StFetch;
            StBranchEx: state_d = StFetch;
            StImmEx:    state_d = StImmWb;
            StImmWb:    state_d = StFetch;
            StJEx:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Immediate-class ALU operation and extension mode, shared by IMMEX and IMMWB
    always_comb begin
        imm_aluop = AluAdd;
        imm_extop = 1'b0;
        case (op)
            OpSlti: imm_aluop = AluSlt;
            OpAndi: begin
                imm_aluop = AluAnd;
                imm_extop = 1'b1;
            end
            OpOri: begin
                imm_aluop = AluOr;
                imm_extop = 1'b1;
            end
            OpXori: begin
                imm_aluop = AluXor;
                imm_extop = 1'b1;
            end
            OpLui:   imm_aluop = AluLui;
            default: imm_aluop = AluAdd;
        endcase
    end

    // Moore output decode
    always_comb begin
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        branch       = 1'b0;
        branchne     = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        extop        = 1'b0;
        pcsrc        = 2'b00;
        aluop        = AluAdd;
        case (state_q)
            StFetch: begin
                alusrcb     = 2'b01;
                irwrite_raw = mem_rdy;
                pcwrite_raw = mem_rdy;
            end
            StDecode: alusrcb = 2'b11;
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            StMemWr: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluop   = AluFunct;
            end
            StRtypeWb: begin
                regdst       = 1'b1;
                aluop        = AluFunct;
                regwrite_raw = 1'b1;
            end
            StBranchEx: begin
                alusrca  = 1'b1;
                aluop    = AluSub;
                pcsrc    = 2'b01;
                branch   = (op == OpBeq);
                branchne = (op == OpBne);
            end
            StImmEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop;
                extop   = imm_extop;
            end
            StImmWb: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                aluop        = imm_aluop;
                extop        = imm_extop;
                regwrite_raw = 1'b1;
            end
            StJEx: begin
                pcsrc       = 2'b10;
                pcwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural write strobes must be dead while reset is held, even in FETCH
    assign pcwrite    = pcwrite_raw & reset_n;
    assign irwrite    = irwrite_raw & reset_n;
    assign memwrite   = memwrite_raw & reset_n;
    assign regwrite   = regwrite_raw & reset_n;
    assign illegal_op = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mcctrl.sv
// Bench for mips_mcctrl: per-instruction cycle plans built from the opcode class,
// checked cycle by cycle against an expected-output table.
module tb_mips_mcctrl;

    localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMB = 4, PMW = 5;
    localparam int PRE = 6, PRW = 7, PBR = 8, PIE = 9, PIW = 10, PJ = 11;
    localparam int CR = 0, CLW = 1, CSW = 2, CBR = 3, CIMM = 4, CJ = 5, CILL = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, branch, branchne, iord, memwrite, irwrite, regwrite;
    logic       regdst, memtoreg, alusrca, extop, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop, state;
    logic [18:0] got_vec;

    int checks = 0;
    int errors = 0;
    bit ill_pending = 1'b0;

    mips_mcctrl #(.USE_MEM_READY(1'b1), .STATE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .branchne(branchne), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .extop(extop),
        .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign got_vec = {pcwrite, branch, branchne, iord, memwrite, irwrite, regwrite, regdst,
                      memtoreg, alusrca, alusrcb, extop, pcsrc, aluop};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int op_class(input logic [5:0] o);
        case (o)
            6'd0:                             return CR;
            6'd35:                            return CLW;
            6'd43:                            return CSW;
            6'd4, 6'd5:                       return CBR;
            6'd8, 6'd10, 6'd12, 6'd13, 6'd14,
            6'd15:                            return CIMM;
            6'd2:                             return CJ;
            default:                          return CILL;
        endcase
    endfunction

    // Expected output vector for a step of an instruction, in the got_vec order
    function automatic logic [18:0] exp_out(input int ph, input logic [5:0] o, input bit mr);
        logic pcw, br, brn, ior, mw, irw, rw, rd, m2r, asa, ext;
        logic [1:0] asb, pcs;
        logic [3:0] aop;
        {pcw, br, brn, ior, mw, irw, rw, rd, m2r, asa, ext} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 4'd0;
        case (ph)
            PF:  begin asb = 2'b01; irw = mr; pcw = mr; end
            PD:  asb = 2'b11;
            PMA: begin asa = 1'b1; asb = 2'b10; end
            PMR: ior = 1'b1;
            PMB: begin m2r = 1'b1; rw = 1'b1; end
            PMW: begin ior = 1'b1; mw = 1'b1; end
            PRE: begin asa = 1'b1; aop = 4'd15; end
            PRW: begin rd = 1'b1; aop = 4'd15; rw = 1'b1; end
            PBR: begin asa = 1'b1; aop = 4'd1; pcs = 2'b01; br = (o == 6'd4); brn = (o == 6'd5); end
            PIE, PIW: begin
                asa = 1'b1; asb = 2'b10; rw = (ph == PIW);
                case (o)
                    6'd10:   aop = 4'd2;
                    6'd12:   begin aop = 4'd4; ext = 1'b1; end
                    6'd13:   begin aop = 4'd5; ext = 1'b1; end
                    6'd14:   begin aop = 4'd6; ext = 1'b1; end
                    6'd15:   aop = 4'd7;
                    default: aop = 4'd0;
                endcase
            end
            PJ:  begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {pcw, br, brn, ior, mw, irw, rw, rd, m2r, asa, asb, ext, pcs, aop};
    endfunction

    // wf/wm: not-ready cycles in FETCH / in the memory step; abort_at stops after that step
    task automatic run_instr(input logic [5:0] o, input int wf, input int wm, input int abort_at);
        int ph_q[$];
        bit mr_q[$];
        int cls;
        cls = op_class(o);
        for (int k = 0; k < wf; k++) begin ph_q.push_back(PF); mr_q.push_back(1'b0); end
        ph_q.push_back(PF); mr_q.push_back(1'b1);
        ph_q.push_back(PD); mr_q.push_back(1'($urandom));
        case (cls)
            CR:   begin ph_q.push_back(PRE); ph_q.push_back(PRW); end
            CLW, CSW: begin
                ph_q.push_back(PMA);
                for (int k = 0; k < wm; k++) ph_q.push_back(cls == CLW ? PMR : PMW);
                ph_q.push_back(cls == CLW ? PMR : PMW);
                if (cls == CLW) ph_q.push_back(PMB);
            end
            CBR:  ph_q.push_back(PBR);
            CIMM: begin ph_q.push_back(PIE); ph_q.push_back(PIW); end
            CJ:   ph_q.push_back(PJ);
            default: ;
        endcase
        // Memory-step readiness: wm not-ready cycles then ready; elsewhere random
        for (int k = mr_q.size(); k < ph_q.size(); k++) begin
            if ((ph_q[k] == PMR || ph_q[k] == PMW) && (k + 1 < ph_q.size()) &&
                (ph_q[k + 1] == ph_q[k]))
                mr_q.push_back(1'b0);
            else if (ph_q[k] == PMR || ph_q[k] == PMW)
                mr_q.push_back(1'b1);
            else
                mr_q.push_back(1'($urandom));
        end
        for (int i = 0; i < ph_q.size(); i++) begin
            @(negedge clk);
            op = o;
            mem_ready = mr_q[i];
            #1;
            check("state", 32'(state), 32'(ph_q[i]));
            check("outputs", 32'(got_vec), 32'(exp_out(ph_q[i], o, mr_q[i])));
            check("illegal_op", 32'(illegal_op), 32'(ill_pending));
            ill_pending = (ph_q[i] == PD) && (cls == CILL);
            if (i == abort_at) break;
        end
    endtask

    task automatic apply_reset();
        mem_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(PF));
        check("rst_memwrite", 32'(memwrite), 32'd0);
        check("rst_pcwrite", 32'(pcwrite), 32'd0);
        check("rst_irwrite", 32'(irwrite), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        ill_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'(PF));
        check("rst_hold_pcwrite", 32'(pcwrite), 32'd0);
        mem_ready = 1'b0;
        reset_n = 1'b1;
    endtask

    logic [5:0] legal_ops [12] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8,
                                   6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd2};

    initial begin
        logic [5:0] rop;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        apply_reset();

        run_instr(6'd35, 2, 1, -1);  // lw: 8 cycles with waits
        run_instr(6'd0, 0, 0, -1);   // R-type
        run_instr(6'd13, 0, 0, -1);  // ori
        run_instr(6'd10, 0, 0, -1);  // slti
        run_instr(6'd5, 0, 0, -1);   // bne
        run_instr(6'd2, 0, 0, -1);   // j
        run_instr(6'd63, 0, 0, -1);  // illegal
        run_instr(6'd4, 0, 0, -1);   // beq; also sees the illegal_op pulse

        // sw aborted by reset while held in MEMWR with memwrite asserted
        run_instr(6'd43, 0, 1, 3);
        check("memwrite_before_rst", 32'(memwrite), 32'd1);
        apply_reset();
        run_instr(6'd0, 0, 0, -1);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) < 8) rop = legal_ops[$urandom_range(0, 11)];
            else rop = 6'($urandom_range(0, 63));
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        run_instr(6'd0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
